// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with per-digit hex decode,
// decimal point, blanking and blink. All display outputs are registered and active-low.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned BLINK_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned SlotW  = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(DIGIT_CYCLES - 1);
  localparam logic [SlotW-1:0]  SlotGuard = SlotW'(GUARD_CYCLES);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  logic [SlotW-1:0]      slot_q, slot_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_q, frame_d;

  logic [3:0] nib;
  logic       sel_dp, sel_blank, sel_blink, dark;

  // Segment pattern g..a, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan position and blink phase.
  always_comb begin
    slot_d      = slot_q;
    idx_d       = idx_q;
    frame_d     = 1'b0;
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    phase_d     = phase_q;

    if (enable) begin
      if (slot_q == SlotLast) begin
        slot_d = '0;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          frame_d = 1'b1;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end else begin
        slot_d = slot_q + SlotW'(1);
      end
    end

    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Per-digit select and display decode from the current scan position.
  always_comb begin
    nib       = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_blink = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = digits[4*i +: 4];
        sel_dp    = dp_in[i];
        sel_blank = blank[i];
        sel_blink = blink[i];
      end
    end

    dark = !enable || (slot_q < SlotGuard) || sel_blank || (sel_blink && phase_q);

    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!dark) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IdxW'(i)) an_d[i] = 1'b0;
      end
      seg_d = hex_to_seg(nib);
      dp_d  = ~sel_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, 1 guard cycle,
// 32-cycle blink half-period.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int k = 0;  // rising edges since reset release

  seg7_scan_driver #(
    .NUM_DIGITS  (4),
    .DIGIT_CYCLES(4),
    .GUARD_CYCLES(1),
    .BLINK_CYCLES(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .digits    (digits),
    .dp_in     (dp_in),
    .blank     (blank),
    .blink     (blink),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Expected {an, seg, dp} after edge n of uninterrupted scanning from reset.
  function automatic logic [11:0] expect_out(input int n);
    int s, i, ph;
    logic [3:0] a;
    s  = (n - 1) % 4;
    i  = ((n - 1) / 4) % 4;
    ph = ((n - 1) / 32) % 2;
    if (s < 1 || blank[i] || (blink[i] && ph == 1)) return {4'hF, 7'h7F, 1'b1};
    a    = 4'hF;
    a[i] = 1'b0;
    return {a, seg_of(digits[4*i +: 4]), ~dp_in[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    enable = 1'b1; digits = 16'h3210; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft got %b want 0", frame_tick); end
    do_reset();
    step();
    checks++; if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL guard_dark got an=%b seg=%b dp=%b want dark", an, seg, dp);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({an, seg} !== {4'b1110, 7'b1000000}) begin
        errors++; $display("FAIL first_slot c=%0d got an=%b seg=%b want 1110/1000000", c, an, seg);
      end
    end
  endtask

  task automatic test_scan();
    enable = 1'b1; digits = 16'h3210; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    do_reset();
    for (int c = 0; c < 64; c++) begin
      step();
      checks++; if ({an, seg, dp} !== expect_out(k)) begin
        errors++; $display("FAIL scan k=%0d got %b want %b", k, {an, seg, dp}, expect_out(k));
      end
      checks++; if (frame_tick !== (k % 16 == 0)) begin
        errors++; $display("FAIL frame_tick k=%0d got %b want %b", k, frame_tick, (k % 16 == 0));
      end
    end
  endtask

  task automatic test_decode();
    enable = 1'b1; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    for (int v = 0; v < 16; v++) begin
      digits = {12'h321, 4'(v)};
      do_reset();
      step();
      step();
      checks++; if ({an, seg} !== {4'b1110, seg_of(4'(v))}) begin
        errors++; $display("FAIL decode v=%h got an=%b seg=%b want 1110/%b", v, an, seg, seg_of(4'(v)));
      end
    end
    // Nibble change mid-slot shows on the next cycle.
    digits[3:0] = 4'hA;
    step();
    checks++; if (seg !== 7'b0001000) begin
      errors++; $display("FAIL mid_slot_change got %b want 0001000", seg);
    end
    digits = 16'h3210; dp_in = 4'b0001;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      step();
      checks++; if ({an, seg, dp} !== expect_out(k)) begin
        errors++; $display("FAIL dp k=%0d got %b want %b", k, {an, seg, dp}, expect_out(k));
      end
    end
    dp_in = 4'h0;
  endtask

  task automatic test_blank();
    enable = 1'b1; digits = 16'h3210; dp_in = 4'h0; blank = 4'b0100; blink = 4'h0;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      step();
      checks++; if ({an, seg, dp} !== expect_out(k) || an === 4'b1011) begin
        errors++; $display("FAIL blank k=%0d got %b want %b", k, {an, seg, dp}, expect_out(k));
      end
    end
    blank = 4'h0;
  endtask

  task automatic test_blink();
    enable = 1'b1; digits = 16'h3210; dp_in = 4'h0; blank = 4'h0; blink = 4'b0001;
    do_reset();
    for (int c = 0; c < 128; c++) begin
      step();
      checks++; if ({an, seg, dp} !== expect_out(k)) begin
        errors++; $display("FAIL blink k=%0d got %b want %b", k, {an, seg, dp}, expect_out(k));
      end
    end
    blink = 4'h0;
  endtask

  task automatic test_enable();
    enable = 1'b1; digits = 16'h3210; dp_in = 4'h0; blank = 4'h0; blink = 4'h0;
    do_reset();
    repeat (6) step();  // now at digit 1, slot counter 2
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++; if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++; $display("FAIL enable_off c=%0d got an=%b seg=%b dp=%b ft=%b want dark", c, an, seg, dp, frame_tick);
      end
    end
    enable = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if ({an, seg} !== {4'b1101, 7'b1111001}) begin
        errors++; $display("FAIL resume_d1 c=%0d got an=%b seg=%b want 1101/1111001", c, an, seg);
      end
    end
    step();
    checks++; if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL resume_guard got an=%b seg=%b dp=%b want dark", an, seg, dp);
    end
    step();
    checks++; if ({an, seg} !== {4'b1011, 7'b0100100}) begin
      errors++; $display("FAIL resume_d2 got an=%b seg=%b want 1011/0100100", an, seg);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; digits = 16'h3210; dp_in = 4'b0100; blank = 4'h0; blink = 4'h0;
    do_reset();
    repeat (10) step();
    checks++; if ({an, dp} !== {4'b1011, 1'b0}) begin
      errors++; $display("FAIL pre_reset got an=%b dp=%b want 1011/0", an, dp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++; $display("FAIL async_reset got an=%b seg=%b dp=%b ft=%b want dark", an, seg, dp, frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    step();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL restart_guard got an=%b want 1111", an); end
    step();
    checks++; if ({an, seg} !== {4'b1110, 7'b1000000}) begin
      errors++; $display("FAIL restart_d0 got an=%b seg=%b want 1110/1000000", an, seg);
    end
    dp_in = 4'h0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_blank();
    test_blink();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for the alarm clock front panel. It replaces the single-digit, fixed-anode decoder with a time-multiplexed scanner across NUM_DIGITS digits. Per digit it provides full hex decode, decimal point, blanking and blink. It sits between the time/alarm datapath and the board's common-anode display, and all its outputs are active-low.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8); width of an and of the per-digit control buses
DIGIT_CYCLES, 100000, clk cycles each digit is held (1 ms at 100 MHz); must be >= 2
GUARD_CYCLES, 2, anti-ghosting dark cycles at the start of each digit slot; must be < DIGIT_CYCLES
BLINK_CYCLES, 50000000, clk cycles per blink half-period (0.5 s at 100 MHz); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scan and display; 0 = all digits dark, scan frozen
digits  in  4*NUM_DIGITS  hex nibble per digit; digit i = digits[4*i+3:4*i]
dp_in  in  NUM_DIGITS  1 = decimal point lit for digit i
blank  in  NUM_DIGITS  1 = digit i dark (segments and dp)
blink  in  NUM_DIGITS  1 = digit i dark during the blink-off phase
seg  out  7  segment cathodes, active-low, seg[0]=a ... seg[6]=g
dp  out  1  decimal-point cathode, active-low
an  out  NUM_DIGITS  anodes, active-low, an[i] drives digit i
frame_tick  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - an = all 1s, seg = 7'h7F, dp = 1, frame_tick = 0
  - digit index = 0, slot counter = 0, blink counter = 0, blink phase = 0 (visible)
- Slot counter:
  - width $clog2(DIGIT_CYCLES); counts 0..DIGIT_CYCLES-1 while enable=1.
  - At terminal count it returns to 0 and the digit index advances.
  - Index wraps from NUM_DIGITS-1 to 0. In that same cycle frame_tick=1 for exactly one cycle.
- Blink counter:
  - counts 0..BLINK_CYCLES-1 regardless of enable.
  - At terminal count it returns to 0 and the blink phase toggles.
  - Phase 1 = off phase.
- Outputs are registered, with 1-cycle latency from the index, counter and input values to seg/dp/an.
- Digit i is dark when any of the following holds:
  - enable=0
  - slot counter < GUARD_CYCLES
  - blank[i]=1
  - blink[i]=1 and phase=1
- When dark: an = all 1s, seg = 7'h7F, dp = 1.
- Otherwise: an has only bit i low, seg = decode(nibble i), dp = ~dp_in[i].
- Decode table, seg[6:0] as g..a, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Inputs are sampled every cycle, so a changed nibble appears on the next cycle within the current slot. No capture per frame.
- enable deasserted mid-slot:
  - slot counter and index hold; the outputs are dark on the next cycle.
  - On re-enable, counting resumes from the held values.
- More than one dark condition at once: dark; no priority among them.
- NUM_DIGITS=1: index stays 0; frame_tick pulses at every slot terminal count.
- Reset asserted mid-operation: all state returns to its reset value immediately (asynchronously); scan restarts at digit 0.

Test Plan:
- Parameters N=4, DIGIT_CYCLES=4, GUARD=1, BLINK=32; digits=16'h3210, dp_in=0, blank=0, blink=0, enable=1, rst_n released:
  - 1 dark cycle, then an=1110 and seg=1000000 for 3 cycles
  - next slot: an=1101, seg=1111001
  - then 1011 / 0100100, then 0111 / 0110000
  - frame_tick high one cycle at the 3->0 wrap, i.e. every 16 cycles
- Sweep each nibble 0..F on digit 0 -> seg matches the decode table for all 16 values; dp_in=0001 -> dp=0 only while an=1110.
- blank=0100 -> an never shows 1011; the digit-2 slot is fully dark (an all 1s, seg=7F, dp=1); the other slots are unaffected.
- blink=0001 -> digit 0 visible in the first 32 cycles and dark in the next 32; this alternation repeats; digits 1-3 are never affected.
- Drop enable at slot counter 2 of digit 1 and hold for 10 cycles:
  - outputs dark from the next cycle; no frame_tick
  - after re-enable, digit 1 completes its remaining slot cycles, then digit 2
- Assert rst_n=0 mid-slot of digit 2 -> same cycle an=all 1s, seg=7F, dp=1; after release, the scan restarts at digit 0 with the guard cycle.
